// File: rtl/req_encoder8_3.sv
// Sequential 8-to-3 request encoder: latches request lines into a pending
// vector and issues one index at a time over a valid/ready handshake.
module req_encoder8_3 #(
   parameter bit RR = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i,
   input  logic       e,
   output logic [2:0] o,
   output logic       v,
   input  logic       rdy,
   output logic [7:0] pend,
   output logic       drop
);

   logic [7:0] pend_q, pend_d;
   logic [2:0] o_q, o_d;
   logic       v_q, v_d;
   logic       drop_q, drop_d;
   logic [2:0] ptr_q, ptr_d;

   logic [2:0] sel;
   logic [2:0] idx;
   logic       load;
   logic [7:0] clr;
   logic [7:0] set;

   // Descending scan so the candidate closest to the search start is assigned last.
   always_comb begin
      sel = 3'd0;
      idx = 3'd0;
      if (RR) begin
         for (int k = 8; k >= 1; k--) begin
            idx = ptr_q + 3'(k);
            if (pend_q[idx]) sel = idx;
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            if (pend_q[k]) sel = 3'(k);
         end
      end
   end

   always_comb begin
      load   = (~v_q | rdy) & (|pend_q);
      clr    = load ? (8'd1 << sel) : 8'd0;
      set    = e ? i : 8'd0;
      pend_d = (pend_q & ~clr) | set;
      drop_d = e & (|(i & pend_q & ~clr));
      o_d    = o_q;
      v_d    = v_q;
      ptr_d  = ptr_q;
      if (load) begin
         o_d = sel;
         v_d = 1'b1;
         if (RR) ptr_d = sel;
      end else if (v_q & rdy) begin
         v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 8'h00;
         o_q    <= 3'd0;
         v_q    <= 1'b0;
         drop_q <= 1'b0;
         ptr_q  <= 3'd7;
      end else begin
         pend_q <= pend_d;
         o_q    <= o_d;
         v_q    <= v_d;
         drop_q <= drop_d;
         ptr_q  <= ptr_d;
      end
   end

   assign o    = o_q;
   assign v    = v_q;
   assign pend = pend_q;
   assign drop = drop_q;

endmodule

// File: tb/tb_req_encoder8_3.sv
// Bench for req_encoder8_3: fixed-priority and round-robin instances driven
// in parallel, checked against constant tables, directed sequences and a model.
module tb_req_encoder8_3;

   logic       clk;
   logic       rst_n;
   logic [7:0] i;
   logic       e;
   logic       rdy;

   logic [2:0] o0, o1;
   logic       v0, v1;
   logic [7:0] pend0, pend1;
   logic       drop0, drop1;

   int tests;
   int fails;

   req_encoder8_3 #(.RR(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .i(i), .e(e), .o(o0), .v(v0),
      .rdy(rdy), .pend(pend0), .drop(drop0)
   );

   req_encoder8_3 #(.RR(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i(i), .e(e), .o(o1), .v(v1),
      .rdy(rdy), .pend(pend1), .drop(drop1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state, index 0 = fixed priority, 1 = round-robin
   bit   mp [2][8];
   int   mo [2];
   bit   mv [2];
   bit   md [2];
   int   mptr [2];

   typedef struct {
      logic [7:0] i;
      logic       e;
      logic       rdy;
      logic [2:0] o;
      logic       v;
      logic [7:0] pend;
      logic       drop;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mpend(int m);
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < 8; k++) if (mp[m][k]) r[k] = 1'b1;
      return r;
   endfunction

   function automatic int model_pick(int m);
      if (m == 0) begin
         for (int k = 0; k < 8; k++) if (mp[m][k]) return k;
      end else begin
         for (int n = 1; n <= 8; n++) if (mp[m][(mptr[m] + n) % 8]) return (mptr[m] + n) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 8; k++) mp[m][k] = 1'b0;
         mo[m] = 0; mv[m] = 1'b0; md[m] = 1'b0; mptr[m] = 7;
      end
   endtask

   task automatic model_edge(int m);
      int  s;
      bit  any;
      bit  ld;
      bit  hit;
      any = 1'b0;
      for (int k = 0; k < 8; k++) if (mp[m][k]) any = 1'b1;
      ld  = (!mv[m] || rdy) && any;
      s   = ld ? model_pick(m) : -1;
      hit = 1'b0;
      for (int k = 0; k < 8; k++) if (e && i[k] && mp[m][k] && k != s) hit = 1'b1;
      md[m] = hit;
      if (ld) begin
         mo[m] = s; mv[m] = 1'b1;
         if (m == 1) mptr[m] = s;
         mp[m][s] = 1'b0;
      end else if (mv[m] && rdy) begin
         mv[m] = 1'b0;
      end
      if (e) for (int k = 0; k < 8; k++) if (i[k]) mp[m][k] = 1'b1;
   endtask

   task automatic compare_model();
      check("d0_o",    {5'd0, o0}, 8'(mo[0]));
      check("d0_v",    {7'd0, v0}, {7'd0, mv[0]});
      check("d0_pend", pend0,      mpend(0));
      check("d0_drop", {7'd0, drop0}, {7'd0, md[0]});
      check("d1_o",    {5'd0, o1}, 8'(mo[1]));
      check("d1_v",    {7'd0, v1}, {7'd0, mv[1]});
      check("d1_pend", pend1,      mpend(1));
      check("d1_drop", {7'd0, drop1}, {7'd0, md[1]});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_d0_pend", pend0, 8'h00);
      check("rst_d0_v",    {7'd0, v0}, 8'h00);
      check("rst_d0_o",    {5'd0, o0}, 8'h00);
      check("rst_d0_drop", {7'd0, drop0}, 8'h00);
      check("rst_d1_pend", pend1, 8'h00);
      check("rst_d1_v",    {7'd0, v1}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      i = 8'h00; e = 1'b0; rdy = 1'b0;
      rst_n = 1'b1;
      #2;
      do_reset();

      // fixed-priority drain of 8'hA4 with rdy held high
      tbl[0] = '{i: 8'hA4, e: 1'b1, rdy: 1'b1, o: 3'd0, v: 1'b0, pend: 8'hA4, drop: 1'b0};
      tbl[1] = '{i: 8'h00, e: 1'b1, rdy: 1'b1, o: 3'd2, v: 1'b1, pend: 8'hA0, drop: 1'b0};
      tbl[2] = '{i: 8'h00, e: 1'b1, rdy: 1'b1, o: 3'd5, v: 1'b1, pend: 8'h80, drop: 1'b0};
      tbl[3] = '{i: 8'h00, e: 1'b1, rdy: 1'b1, o: 3'd7, v: 1'b1, pend: 8'h00, drop: 1'b0};
      tbl[4] = '{i: 8'h00, e: 1'b1, rdy: 1'b1, o: 3'd7, v: 1'b0, pend: 8'h00, drop: 1'b0};
      for (int n = 0; n < 5; n++) begin
         i = tbl[n].i; e = tbl[n].e; rdy = tbl[n].rdy;
         step();
         check($sformatf("tbl%0d_o", n),    {5'd0, o0},    {5'd0, tbl[n].o});
         check($sformatf("tbl%0d_v", n),    {7'd0, v0},    {7'd0, tbl[n].v});
         check($sformatf("tbl%0d_pend", n), pend0,         tbl[n].pend);
         check($sformatf("tbl%0d_drop", n), {7'd0, drop0}, {7'd0, tbl[n].drop});
      end

      // reset mid-handshake: pend=24, v=1, o=3
      rdy = 1'b0; i = 8'h08; step();
      i = 8'h24; step();
      check("mh_o",    {5'd0, o0}, 8'd3);
      check("mh_pend", pend0, 8'h24);
      i = 8'h00;
      do_reset();
      for (int n = 0; n < 3; n++) begin
         step();
         check("idle_v", {7'd0, v0}, 8'h00);
         check("idle_pend", pend0, 8'h00);
      end

      // backpressure
      rdy = 1'b0; i = 8'h10; step();
      i = 8'h00;
      for (int n = 0; n < 5; n++) begin
         if (n == 2) i = 8'h01;
         else i = 8'h00;
         step();
         check("bp_o", {5'd0, o0}, 8'd4);
         check("bp_v", {7'd0, v0}, 8'h01);
      end
      check("bp_pend", pend0, 8'h01);
      i = 8'h00; rdy = 1'b1; step();
      check("bp_release_o", {5'd0, o0}, 8'd0);
      check("bp_release_v", {7'd0, v0}, 8'h01);
      step();
      check("bp_empty_v", {7'd0, v0}, 8'h00);

      // round-robin fairness with all requests held
      do_reset();
      i = 8'hFF; e = 1'b1; rdy = 1'b1;
      step();
      check("rr_first_v", {7'd0, v1}, 8'h00);
      for (int n = 0; n < 9; n++) begin
         step();
         check("rr_o",    {5'd0, o1}, 8'(n % 8));
         check("rr_v",    {7'd0, v1}, 8'h01);
         check("rr_drop", {7'd0, drop1}, 8'h01);
      end
      i = 8'h00;
      for (int n = 0; n < 10; n++) step();

      // set/clear collision: bit 0 issued twice, no drop
      i = 8'h01; step();
      check("col_pend0", pend0, 8'h01);
      i = 8'h01; step();
      check("col_o",    {5'd0, o0}, 8'd0);
      check("col_pend", pend0, 8'h01);
      check("col_drop", {7'd0, drop0}, 8'h00);
      i = 8'h00; step();
      check("col_o2", {5'd0, o0}, 8'd0);
      check("col_v2", {7'd0, v0}, 8'h01);
      step(); step();

      // repeated arrival while output is blocked
      rdy = 1'b0; i = 8'h08; step();
      i = 8'h02; step();
      check("dr_first", {7'd0, drop0}, 8'h00);
      i = 8'h02; step();
      check("dr_second", {7'd0, drop0}, 8'h01);
      i = 8'h00; step();
      check("dr_pulse_end", {7'd0, drop0}, 8'h00);
      rdy = 1'b1;
      for (int n = 0; n < 4; n++) step();

      // enable gating
      do_reset();
      e = 1'b0; i = 8'hFF;
      for (int n = 0; n < 4; n++) begin
         step();
         check("eg_pend", pend0, 8'h00);
         check("eg_v", {7'd0, v0}, 8'h00);
      end
      e = 1'b1; i = 8'h06; step();
      e = 1'b0; i = 8'hFF; step();
      check("eg_drain1", {5'd0, o0}, 8'd1);
      step();
      check("eg_drain2", {5'd0, o0}, 8'd2);
      check("eg_drain_pend", pend0, 8'h00);
      step();

      // randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         i   = 8'($urandom) & 8'($urandom);
         e   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/req_encoder8_3.md
Name: req_encoder8_3

Overview:
- Sequential 8-to-3 request encoder. It is the inverse of the team's 3-to-8 enable decoder.
- Collects up to 8 request lines into a pending register.
- Emits one 3-bit index at a time over a valid/ready handshake, clearing each pending bit as its index is issued.
- Sits in front of the 3-to-8 decoder or processor control logic, which consumes the encoded indices.

Parameters:
- RR, 0: arbitration mode. 0 = fixed priority, bit 0 highest. 1 = round-robin, search starts one above the last issued index.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronised externally.
- i  input  8  request lines, sampled each rising edge while e=1.
- e  input  1  capture enable. When 0, i is ignored but draining continues.
- o  output  3  encoded index of the issued request; registered.
- v  output  1  o is valid; registered.
- rdy  input  1  consumer accepts o when v=1 and rdy=1 on a rising edge.
- pend  output  8  current pending vector; registered; excludes the index currently held on o.
- drop  output  1  one-cycle pulse: a request arrived on a bit that was already pending.

Behaviour:
- Reset (rst_n=0, asynchronous): pend=8'h00, o=3'd0, v=0, drop=0, RR pointer=3'd7 (so the first RR search starts at bit 0). All state clears even mid-handshake; an offered index is lost.
- Capture, per rising edge:
  - set = e ? i : 8'h00.
  - next pend = (pend & ~clr) | set, where clr is the one-hot bit loaded onto o this edge (else 0).
  - Set wins over clr on the same bit: the new request stays pending and is issued later.
- drop = e & |(i & pend & ~clr); registered, high for exactly one cycle per offending edge. The request is merged, not counted.
- Load condition: load = (~v | rdy) & |pend.
- On load:
  - o = selected index, v=1, and that bit of pend clears.
  - RR=1: the pointer updates to the selected index.
- Accept without load: if v & rdy & ~|pend, then v=0 and o holds its last value.
- While v=1 & rdy=0: o and v hold stable, and pend may keep accumulating.
- Selection is combinational over the registered pend only. Requests sampled on the same edge are not eligible until the next edge.
- Fixed priority (RR=0): lowest set bit of pend wins.
- Round-robin (RR=1):
  - Search from (ptr+1) mod 8 upward, wrapping 7→0; the first set bit wins.
  - Index arithmetic is 3-bit modulo 8.
  - The pointer only updates on load.
- Latency: a request on bit k with e=1 at edge N sets pend[k] after N. With the output free, o=k and v=1 after edge N+1 (2-cycle latency).
- Throughput: with rdy held 1, one index per cycle until pend is empty.
- pend=8'h00 and v=0 is the idle state. No other FSM state exists beyond the v flag and the RR pointer.
- i=8'hFF in one cycle: all eight bits go pending and drain over 8 consecutive accepted cycles.
- rdy with v=0 has no effect.

Test Plan:
- Reset mid-handshake: pend=8'h24, v=1, o=3'd3, then rst_n=0 → immediately pend=8'h00, v=0, o=0, drop=0. After release with i=0, outputs stay idle.
- Fixed priority (RR=0): i=8'hA4, e=1 for one cycle, rdy=1 → o sequence 2,5,7 on three consecutive cycles with v=1; v=0 on the fourth cycle; pend 8'hA0, 8'h80, 8'h00.
- Backpressure: rdy=0, single request i=8'h10 → o=4, v=1 held for 5 cycles unchanged. A further i=8'h01 meanwhile shows pend=8'h01. Raising rdy yields o=0 on the next cycle.
- Round-robin (RR=1): pend=8'hFF held by i=8'hFF, e=1 every cycle, rdy=1 → o cycles 0,1,…,7,0 with no starvation; drop=1 on cycles where a held request re-hits a still-pending bit.
- Set/clear collision and drop:
  - i=8'h01 → pend=8'h01.
  - Next cycle i=8'h01 again while bit 0 loads to o → drop=0, and pend=8'h01 (set wins), so o=0 is issued twice.
  - i=8'h02 twice with rdy=0 → second arrival gives drop=1 for one cycle.
- Enable gating: e=0, i=8'hFF for 4 cycles → pend stays 8'h00, v=0. With pend=8'h06 preloaded, e=0 → still drains o=1 then o=2.
